prog_loader: RTL and testbench

Serial program loader sitting directly upstream of the mini-CPU's instruction ROM. It receives a framed program image over a UART line and writes it word-by-word into the 256 × 16-bit program memory read by the MAR/MDR fetch path. It holds the CPU in reset for the whole download and releases it only after the checksum verifies.

---
 rtl/prog_loader_pkg.sv | 25 ++
 rtl/prog_loader_uart_rx.sv | 107 ++++++++++
 rtl/prog_loader.sv | 152 +++++++++++++++
 tb/tb_prog_loader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared CPU package: loader constants, ROM geometry and state encodings.
package prog_loader_pkg;

  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
  localparam int unsigned PROG_ADDR_W = 8;
  localparam int unsigned PROG_DATA_W = 16;

  // Loader frame-parsing states
  typedef enum logic [2:0] {
    IDLE,
    LEN,
    HI,
    LO,
    CSUM
  } ld_state_e;

  // UART receiver bit-timing states
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/prog_loader_uart_rx.sv
// UART 8N1 receiver: synchronizer, mid-bit sampler and shifter.
module uart_rx
  import prog_loader_pkg::*;
#(
  parameter int unsigned DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int unsigned    CNT_W    = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(DIV / 2 - 1);

  logic             rx_meta, rx_sync, rx_prev;
  rx_state_e        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [7:0]       shift, shift_d;
  logic [7:0]       rx_byte_d;
  logic             rx_valid_d, rx_ferr_d;

  // Two-flop synchronizer plus one delayed copy for falling-edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver state and registered byte/strobe outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      bit_idx  <= bit_idx_d;
      shift    <= shift_d;
      rx_byte  <= rx_byte_d;
      rx_valid <= rx_valid_d;
      rx_ferr  <= rx_ferr_d;
    end
  end

  // Bit timing: half a bit to the start-bit centre, then one bit per sample
  always_comb begin
    state_d    = state;
    cnt_d      = cnt + CNT_W'(1);
    bit_idx_d  = bit_idx;
    shift_d    = shift;
    rx_byte_d  = rx_byte;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_sync) state_d = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_END) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // A glitch that is high again at mid-bit is dropped silently
          state_d   = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == BIT_END) begin
          cnt_d     = '0;
          shift_d   = {rx_sync, shift[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == BIT_END) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_sync) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = shift;
          end else begin
            rx_ferr_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: parses framed UART image into program memory writes.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned TIMEOUT_BITS = 2048
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx,
  output logic                   prog_we,
  output logic [PROG_ADDR_W-1:0] prog_addr,
  output logic [PROG_DATA_W-1:0] prog_data,
  output logic                   cpu_reset,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned DIV    = CLK_HZ / BAUD;
  localparam int unsigned TO_CYC = TIMEOUT_BITS * DIV;
  localparam int unsigned TO_W   = $clog2(TO_CYC + 1);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr;

  uart_rx #(.DIV(DIV)) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  ld_state_e              state, state_d;
  logic [7:0]             cnt, cnt_d;
  logic [PROG_ADDR_W-1:0] addr, addr_d;
  logic [7:0]             hold, hold_d;
  logic [7:0]             sum, sum_d;
  logic                   prog_we_d, cpu_reset_d, busy_d, done_d, err_d;
  logic [PROG_ADDR_W-1:0] prog_addr_d;
  logic [PROG_DATA_W-1:0] prog_data_d;
  logic [TO_W-1:0]        to_cnt;
  logic                   timeout_c;

  assign timeout_c = busy && !rx_valid && (to_cnt == TO_W'(TO_CYC - 1));

  // Inter-byte watchdog: counts only mid-frame, restarts on every byte
  always_ff @(posedge clk) begin
    if (reset || !busy || rx_valid) to_cnt <= '0;
    else                            to_cnt <= to_cnt + TO_W'(1);
  end

  // Loader state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr      <= '0;
      hold      <= '0;
      sum       <= '0;
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      cpu_reset <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      addr      <= addr_d;
      hold      <= hold_d;
      sum       <= sum_d;
      prog_we   <= prog_we_d;
      prog_addr <= prog_addr_d;
      prog_data <= prog_data_d;
      cpu_reset <= cpu_reset_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  // Frame parser: sync, length, hi/lo word pairs, checksum
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    addr_d      = addr;
    hold_d      = hold;
    sum_d       = sum;
    prog_we_d   = 1'b0;
    prog_addr_d = prog_addr;
    prog_data_d = prog_data;
    cpu_reset_d = cpu_reset;
    busy_d      = busy;
    done_d      = 1'b0;
    err_d       = err;
    if (state != IDLE && (rx_ferr || timeout_c)) begin
      // Abort mid-frame; CPU stays held, partial writes are left in place
      err_d   = 1'b1;
      busy_d  = 1'b0;
      state_d = IDLE;
    end else if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_byte == SYNC_BYTE) begin
            err_d       = 1'b0;
            busy_d      = 1'b1;
            cpu_reset_d = 1'b1;
            sum_d       = '0;
            addr_d      = '0;
            state_d     = LEN;
          end
        end
        LEN: begin
          cnt_d   = rx_byte;
          state_d = HI;
        end
        HI: begin
          hold_d  = rx_byte;
          sum_d   = sum + rx_byte;
          state_d = LO;
        end
        LO: begin
          prog_data_d = {hold, rx_byte};
          prog_addr_d = addr;
          prog_we_d   = 1'b1;
          sum_d       = sum + rx_byte;
          addr_d      = addr + PROG_ADDR_W'(1);
          cnt_d       = cnt - 8'd1;
          // LEN of 0 wraps to 255 here, giving the full 256-word image
          state_d     = (cnt_d == 8'd0) ? CSUM : HI;
        end
        CSUM: begin
          busy_d  = 1'b0;
          state_d = IDLE;
          if (rx_byte == sum) begin
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed UART frames, write monitor.
module tb_prog_loader;

  localparam int unsigned CLK_HZ = 800;
  localparam int unsigned BAUD   = 100;
  localparam int unsigned DIV    = CLK_HZ / BAUD;
  localparam int unsigned TO_CYC = 2048 * DIV;

  logic        clk, reset, rx;
  logic        prog_we, cpu_reset, busy, done, err;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data;

  prog_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_BITS(2048)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t         sb[$];
  logic [15:0] words[$];
  int          n_pass  = 0;
  int          n_total = 0;
  int          done_cnt = 0;
  int          viol     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: every write strobe pops the next expected write
  always @(negedge clk) begin
    if (!reset) begin
      if (prog_we) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL extra_write: got addr %0h data %0h, expected no write", prog_addr, prog_data);
        end else begin
          wr_t e;
          e = sb.pop_front();
          check("wr_addr", 32'(prog_addr), 32'(e.a));
          check("wr_data", 32'(prog_data), 32'(e.d));
        end
      end
      if (done) done_cnt++;
      if (busy && !cpu_reset) viol++;
    end
  end

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = good_stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    if (!good_stop) repeat (2 * DIV) @(negedge clk);
  endtask

  // Sends A5, LEN, the words queued in words[], then csum; addresses start at 0
  task automatic send_frame(input logic [7:0] len, input logic [7:0] csum);
    logic [7:0] a;
    a = 8'h00;
    send_byte(8'hA5, 1'b1);
    send_byte(len, 1'b1);
    foreach (words[i]) begin
      wr_t e;
      logic [15:0] w;
      w = words[i];
      e.a = a;
      e.d = w;
      sb.push_back(e);
      send_byte(w[15:8], 1'b1);
      send_byte(w[7:0], 1'b1);
      a = a + 8'd1;
    end
    send_byte(csum, 1'b1);
    idle_bits(2);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"},    32'(prog_we),   32'd0);
    check({tag, "_addr"},  32'(prog_addr), 32'h00);
    check({tag, "_data"},  32'(prog_data), 32'h0000);
    check({tag, "_cpurst"},32'(cpu_reset), 32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
    check({tag, "_err"},   32'(err),       32'd0);
  endtask

  initial begin
    int d0;
    rx    = 1'b1;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    idle_bits(2);

    // Good 2-word frame; checksum 12+34+AB+CD = 1BE -> BE
    d0 = done_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    sb.push_back(wr_t'({8'h00, 16'h1234}));
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    check("good_mid_busy",   32'(busy),      32'd1);
    check("good_mid_cpurst", 32'(cpu_reset), 32'd1);
    sb.push_back(wr_t'({8'h01, 16'hABCD}));
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'hBE, 1'b1);
    idle_bits(2);
    check("good_done",   32'(done_cnt - d0), 32'd1);
    check("good_cpurst", 32'(cpu_reset),     32'd0);
    check("good_err",    32'(err),           32'd0);
    check("good_busy",   32'(busy),          32'd0);
    check("good_hold_a", 32'(prog_addr),     32'h01);
    check("good_hold_d", 32'(prog_data),     32'hABCD);
    check("good_sb",     32'(sb.size()),     32'd0);

    // Bad checksum, then a good frame recovers
    d0 = done_cnt;
    words = '{16'h1234, 16'hABCD};
    send_frame(8'h02, 8'hBF);
    check("bad_done",   32'(done_cnt - d0), 32'd0);
    check("bad_err",    32'(err),           32'd1);
    check("bad_cpurst", 32'(cpu_reset),     32'd1);
    check("bad_busy",   32'(busy),          32'd0);
    send_frame(8'h02, 8'hBE);
    check("rec_done",   32'(done_cnt - d0), 32'd1);
    check("rec_err",    32'(err),           32'd0);
    check("rec_cpurst", 32'(cpu_reset),     32'd0);

    // LEN=0: 256 words {addr,~addr}; each word sums to FF, total 0xFF00 -> 00
    d0 = done_cnt;
    words = {};
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ai;
      ai = 8'(i);
      words.push_back({ai, ~ai});
    end
    send_frame(8'h00, 8'h00);
    check("len0_done",   32'(done_cnt - d0), 32'd1);
    check("len0_sb",     32'(sb.size()),     32'd0);
    check("len0_addr",   32'(prog_addr),     32'hFF);
    check("len0_data",   32'(prog_data),     32'hFF00);
    check("len0_cpurst", 32'(cpu_reset),     32'd0);

    // Framing error on the third word byte, then garbage ignored
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    sb.push_back(wr_t'({8'h00, 16'h1234}));
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'hAB, 1'b0);
    check("ferr_err",    32'(err),       32'd1);
    check("ferr_busy",   32'(busy),      32'd0);
    check("ferr_cpurst", 32'(cpu_reset), 32'd1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    idle_bits(2);
    check("garb_err",    32'(err),       32'd1);
    check("garb_busy",   32'(busy),      32'd0);
    check("garb_cpurst", 32'(cpu_reset), 32'd1);
    check("garb_sb",     32'(sb.size()), 32'd0);
    check("garb_addr",   32'(prog_addr), 32'h00);

    // Timeout: A5 03 12 then silence
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h12, 1'b1);
    repeat (TO_CYC - 400) @(negedge clk);
    check("to_pre_busy", 32'(busy), 32'd1);
    check("to_pre_err",  32'(err),  32'd0);
    repeat (600) @(negedge clk);
    check("to_err",    32'(err),       32'd1);
    check("to_busy",   32'(busy),      32'd0);
    check("to_cpurst", 32'(cpu_reset), 32'd1);

    // Reset between HI and LO
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    check("prerst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    reset = 1'b0;
    idle_bits(2);
    // CA+FE+01+02 = 1CB -> CB
    d0 = done_cnt;
    words = '{16'hCAFE, 16'h0102};
    send_frame(8'h02, 8'hCB);
    check("post_done",   32'(done_cnt - d0), 32'd1);
    check("post_sb",     32'(sb.size()),     32'd0);
    check("post_cpurst", 32'(cpu_reset),     32'd0);
    check("post_err",    32'(err),           32'd0);
    check("cpurst_held", 32'(viol),          32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
